// File: rtl/mode_change_sequencer.sv
// Debounces the mode switches and walks the output-mode FSM through a muted OFF guard before each new mode.
// Latency: 2 sync + DEBOUNCE_CYCLES to debounce, then 2 cycles direct or GUARD_CYCLES+2 via mute; no backpressure.
module mode_change_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GUARD_CYCLES    = 50_000,
  parameter int SETTLE_CYCLES   = 5_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] mode_sw,
  output logic [2:0] mode_select,
  output logic       mute,
  output logic       busy,
  output logic       mode_changed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE_CYCLES);
  localparam logic [GW-1:0] GUARD_LAST  = GW'(GUARD_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUTE,
    APPLY,
    SETTLE
  } state_t;

  logic [2:0]    sync1;
  logic [2:0]    sw_sync;
  logic [DW-1:0] deb_cnt;
  logic [2:0]    deb_mode;

  state_t        state;
  logic [2:0]    target;
  logic [2:0]    applied;
  logic [GW-1:0] guard_cnt;
  logic [SW-1:0] settle_cnt;

  // deb_cnt holds (cycles sw_sync has held its value) - 1; it clears on the edge sw_sync takes a new value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 3'b000;
      sw_sync  <= 3'b000;
      deb_cnt  <= '0;
      deb_mode <= 3'b000;
    end else begin
      sync1   <= mode_sw;
      sw_sync <= sync1;
      if (sync1 != sw_sync) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      if (deb_cnt == DEB_LAST) begin
        deb_mode <= sw_sync;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      target       <= 3'b000;
      applied      <= 3'b000;
      guard_cnt    <= '0;
      settle_cnt   <= '0;
      mode_select  <= 3'b000;
      mute         <= 1'b0;
      busy         <= 1'b0;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (deb_mode != applied) begin
            target <= deb_mode;
            busy   <= 1'b1;
            // OFF and EXTRA drive nothing live, so there is nothing to mute.
            if (applied == 3'b000 || applied == 3'b100) begin
              state <= APPLY;
            end else begin
              state       <= MUTE;
              mode_select <= 3'b000;
              mute        <= 1'b1;
              guard_cnt   <= '0;
            end
          end else begin
            busy <= 1'b0;
            mute <= 1'b0;
          end
        end
        MUTE: begin
          mode_select <= 3'b000;
          if (deb_mode != target) begin
            target    <= deb_mode;
            guard_cnt <= '0;
          end else if (guard_cnt == GUARD_LAST) begin
            state <= APPLY;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        APPLY: begin
          mode_select  <= target;
          applied      <= target;
          mute         <= 1'b0;
          mode_changed <= 1'b1;
          settle_cnt   <= '0;
          state        <= SETTLE;
        end
        SETTLE: begin
          // Switch changes wait here; IDLE picks up whatever deb_mode holds afterwards.
          if (settle_cnt == SETTLE_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mode_change_sequencer.sv
// Directed bench for mode_change_sequencer with DEBOUNCE=4, GUARD=3, SETTLE=2.
// Step timing is counted in ticks from the moment a switch value is driven just after a rising edge.
module tb_mode_change_sequencer;

  logic       clk;
  logic       reset_n;
  logic [2:0] mode_sw;
  logic [2:0] mode_select;
  logic       mute;
  logic       busy;
  logic       mode_changed;

  int checks = 0;
  int errors = 0;

  int mute_cyc  = 0;
  int busy_cyc  = 0;
  int pulse_cyc = 0;
  int zero_cyc  = 0;
  int illegal   = 0;
  int mute_bad  = 0;
  int seen011   = 0;
  logic [2:0] prev_ms = 3'b000;

  int m0, b0, p0, z0, s0;

  mode_change_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .GUARD_CYCLES   (3),
    .SETTLE_CYCLES  (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode_sw     (mode_sw),
    .mode_select (mode_select),
    .mute        (mute),
    .busy        (busy),
    .mode_changed(mode_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit live(input logic [2:0] m);
    return (m != 3'b000) && (m != 3'b100);
  endfunction

  always @(negedge clk) begin
    mute_cyc  <= mute_cyc + (mute ? 1 : 0);
    busy_cyc  <= busy_cyc + (busy ? 1 : 0);
    pulse_cyc <= pulse_cyc + (mode_changed ? 1 : 0);
    zero_cyc  <= zero_cyc + ((mode_select == 3'b000) ? 1 : 0);
    seen011   <= seen011 + ((mode_select == 3'b011) ? 1 : 0);
    mute_bad  <= mute_bad + ((mute && mode_select != 3'b000) ? 1 : 0);
    if (mode_select != prev_ms && live(prev_ms) && live(mode_select)) illegal <= illegal + 1;
    prev_ms <= mode_select;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    m0 = mute_cyc;
    b0 = busy_cyc;
    p0 = pulse_cyc;
    z0 = zero_cyc;
    s0 = seen011;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_changed(input string tag, input int budget);
    int n = 0;
    while (mode_changed !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mode_changed}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    mode_sw = 3'b000;
    repeat (3) tick();
    chk("rst_mode_select", mode_select, 3'b000);
    chk("rst_mute", mute, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_changed", mode_changed, 1'b0);
    reset_n = 1'b1;
    repeat (2) tick();

    // OFF -> 001 goes straight to APPLY.
    snap();
    mode_sw = 3'b001;
    repeat (7) tick();
    chk("t1_pre_apply_sel", mode_select, 3'b000);
    chk("t1_busy_up", busy, 1'b1);
    tick();
    chk("t1_sel", mode_select, 3'b001);
    chk("t1_changed", mode_changed, 1'b1);
    tick();
    chk("t1_pulse_end", mode_changed, 1'b0);
    repeat (4) tick();
    chk("t1_busy_cycles", busy_cyc - b0, 3);
    chk("t1_pulses", pulse_cyc - p0, 1);
    chk("t1_no_mute", mute_cyc - m0, 0);
    chk("t1_idle", busy, 1'b0);

    // 001 -> 101 must pass through a 4-cycle muted OFF.
    snap();
    mode_sw = 3'b101;
    repeat (7) tick();
    chk("t2_mute_sel", mode_select, 3'b000);
    chk("t2_mute", mute, 1'b1);
    chk("t2_busy", busy, 1'b1);
    repeat (3) tick();
    chk("t2_guard_end_sel", mode_select, 3'b000);
    chk("t2_guard_end_mute", mute, 1'b1);
    tick();
    chk("t2_sel", mode_select, 3'b101);
    chk("t2_changed", mode_changed, 1'b1);
    chk("t2_unmute", mute, 1'b0);
    repeat (4) tick();
    chk("t2_zero_cycles", zero_cyc - z0, 4);
    chk("t2_mute_cycles", mute_cyc - m0, 4);
    chk("t2_idle", busy, 1'b0);

    mode_sw = 3'b010;
    wait_changed("setup_010_changed", 40);
    chk("setup_010_sel", mode_select, 3'b010);
    repeat (5) tick();

    // 2-cycle glitches to 110 never debounce.
    snap();
    mode_sw = 3'b110;
    repeat (2) tick();
    mode_sw = 3'b010;
    repeat (2) tick();
    mode_sw = 3'b110;
    repeat (2) tick();
    mode_sw = 3'b010;
    repeat (12) tick();
    chk("t3_deb", dut.deb_mode, 3'b010);
    chk("t3_no_busy", busy_cyc - b0, 0);
    chk("t3_sel", mode_select, 3'b010);
    chk("t3_no_pulse", pulse_cyc - p0, 0);

    // 010 -> 001, then 011 queued during settle, overtaken by 111 mid-guard.
    snap();
    mode_sw = 3'b001;
    repeat (5) tick();
    mode_sw = 3'b011;
    repeat (4) tick();
    mode_sw = 3'b111;
    repeat (2) tick();
    chk("t4_first_sel", mode_select, 3'b001);
    repeat (3) tick();
    chk("t4_mute_entry_sel", mode_select, 3'b000);
    chk("t4_mute_entry", mute, 1'b1);
    repeat (5) tick();
    chk("t4_guard_restarted", mode_select, 3'b000);
    tick();
    chk("t4_sel", mode_select, 3'b111);
    chk("t4_changed", mode_changed, 1'b1);
    repeat (4) tick();
    chk("t4_zero_cycles", zero_cyc - z0, 10);
    chk("t4_mute_cycles", mute_cyc - m0, 10);
    chk("t4_never_011", seen011 - s0, 0);
    chk("t4_idle", busy, 1'b0);

    // 110 arrives during settle of 101 and is applied afterwards via a full mute.
    snap();
    mode_sw = 3'b101;
    repeat (6) tick();
    mode_sw = 3'b110;
    repeat (5) tick();
    chk("t5_sel_101", mode_select, 3'b101);
    chk("t5_changed_101", mode_changed, 1'b1);
    repeat (2) tick();
    chk("t5_settled_sel", mode_select, 3'b101);
    chk("t5_settled_busy", busy, 1'b0);
    tick();
    chk("t5_remute_sel", mode_select, 3'b000);
    chk("t5_remute", mute, 1'b1);
    chk("t5_rebusy", busy, 1'b1);
    repeat (4) tick();
    chk("t5_sel_110", mode_select, 3'b110);
    chk("t5_changed_110", mode_changed, 1'b1);
    chk("t5_mute_cycles", mute_cyc - m0, 8);
    repeat (4) tick();

    // Reset in the middle of a guard, then re-apply directly from OFF.
    mode_sw = 3'b011;
    repeat (8) tick();
    chk("t6_in_mute", mute, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_sel", mode_select, 3'b000);
    chk("t6_rst_mute", mute, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_changed", mode_changed, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    snap();
    repeat (7) tick();
    chk("t6_pre_apply_sel", mode_select, 3'b000);
    chk("t6_busy", busy, 1'b1);
    tick();
    chk("t6_sel", mode_select, 3'b011);
    chk("t6_changed", mode_changed, 1'b1);
    chk("t6_no_mute", mute_cyc - m0, 0);
    repeat (4) tick();

    chk("illegal_transitions", illegal, 0);
    chk("mute_without_off", mute_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
